// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner with 2-FF row sync and tick-based press/release debounce.
// Press accepted (DEBOUNCE_TICKS-1)*SCAN_DIV+1 cycles after first detection; no backpressure, key_valid is a 1-cycle pulse.
module keypad_scan_4x4 #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       is_pressed,
    output logic       key_valid
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    row_m, row_s;
    logic [TW-1:0] tick_cnt;
    logic [1:0]    col_idx, col_nxt;
    logic [1:0]    cand_row, cand_nxt;
    logic [DW-1:0] deb_cnt, deb_nxt;
    logic [3:0]    code_nxt;
    logic          pressed_nxt, valid_nxt;
    logic          tick;
    logic [1:0]    low_idx;
    logic          cand_high;

    assign tick      = (tick_cnt == TICK_LAST);
    assign cand_high = row_s[cand_row];

    // Lowest-index active row wins when several keys share a column.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s[i]) low_idx = 2'(i);
        end
    end

    always_comb begin
        state_nxt   = state;
        col_nxt     = col_idx;
        cand_nxt    = cand_row;
        deb_nxt     = deb_cnt;
        code_nxt    = key_code;
        pressed_nxt = is_pressed;
        valid_nxt   = 1'b0;
        case (state)
            SCAN: begin
                if (tick) begin
                    if (&row_s) begin
                        col_nxt = col_idx + 2'd1;
                        deb_nxt = '0;
                    end else begin
                        cand_nxt = low_idx;
                        if (DEBOUNCE_TICKS == 1) begin
                            code_nxt    = {low_idx, col_idx};
                            pressed_nxt = 1'b1;
                            valid_nxt   = 1'b1;
                            deb_nxt     = '0;
                            state_nxt   = PRESSED;
                        end else begin
                            deb_nxt   = DW'(1);
                            state_nxt = DEBOUNCE;
                        end
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (!cand_high) begin
                        if (deb_cnt + DW'(1) == DEB_DONE) begin
                            code_nxt    = {cand_row, col_idx};
                            pressed_nxt = 1'b1;
                            valid_nxt   = 1'b1;
                            deb_nxt     = '0;
                            state_nxt   = PRESSED;
                        end else begin
                            deb_nxt = deb_cnt + DW'(1);
                        end
                    end else begin
                        col_nxt   = col_idx + 2'd1;
                        deb_nxt   = '0;
                        state_nxt = SCAN;
                    end
                end
            end
            PRESSED: begin
                // Only the held key's row is watched; other keys cannot retrigger.
                if (tick) begin
                    if (cand_high) begin
                        if (deb_cnt + DW'(1) == DEB_DONE) begin
                            pressed_nxt = 1'b0;
                            col_nxt     = col_idx + 2'd1;
                            deb_nxt     = '0;
                            state_nxt   = SCAN;
                        end else begin
                            deb_nxt = deb_cnt + DW'(1);
                        end
                    end else begin
                        deb_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = SCAN;
                deb_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            row_m      <= 4'b1111;
            row_s      <= 4'b1111;
            tick_cnt   <= '0;
            state      <= SCAN;
            col_idx    <= 2'd0;
            cand_row   <= 2'd0;
            deb_cnt    <= '0;
            col_out    <= 4'b1111;
            key_code   <= 4'h0;
            is_pressed <= 1'b0;
            key_valid  <= 1'b0;
        end else begin
            row_m      <= row_in;
            row_s      <= row_m;
            tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);
            state      <= state_nxt;
            col_idx    <= col_nxt;
            cand_row   <= cand_nxt;
            deb_cnt    <= deb_nxt;
            col_out    <= ~(4'b0001 << col_nxt);
            key_code   <= code_nxt;
            is_pressed <= pressed_nxt;
            key_valid  <= valid_nxt;
        end
    end

endmodule
